mux_stim_gen: RTL and testbench

MUX_STIM_GEN -- requirements
Module: mux_stim_gen

---
 rtl/mux_stim_pkg.sv | 23 ++
 rtl/mux_stim_gen_lfsr8.sv | 20 ++
 rtl/mux_stim_gen.sv | 103 ++++++++++
 tb/tb_mux_stim_gen.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_stim_pkg.sv
// Shared types and constants for the 3:1 mux stimulus generator.
package mux_stim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int               LFSR_W    = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  localparam logic [1:0] SEL_IN0 = 2'd0;
  localparam logic [1:0] SEL_IN1 = 2'd1;
  localparam logic [1:0] SEL_IN2 = 2'd2;

  // Fibonacci shift-left; feedback is the parity of the tapped bits 7,5,4,3.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mux_stim_gen_lfsr8.sv
// 8-bit Fibonacci LFSR that advances only when en is high.
module lfsr8
  import mux_stim_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  // An all-zero state would lock up the register, so a zero seed becomes 1.
  always_ff @(posedge clk) begin
    if (!rst_n)
      q <= (seed == '0) ? LFSR_W'(1) : seed;
    else if (en)
      q <= lfsr_next(q);
  end

endmodule

// File: rtl/mux_stim_gen.sv
// Run-based random stimulus generator for a downstream 3:1 mux: each step
// issues three random data bits and a rotating select, MAX_CNT steps per run.
module mux_stim_gen
  import mux_stim_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  parameter int         MAX_CNT   = 10   // legal range 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       hold,
  output logic       in0,
  output logic       in1,
  output logic       in2,
  output logic [1:0] sel,
  output logic       valid,
  output logic [3:0] count,
  output logic       done
);

  localparam logic [3:0] CNT_LAST = 4'(MAX_CNT);

  state_t            state_q, state_d;
  logic [1:0]        sel_d;
  logic [3:0]        count_d;
  logic [2:0]        in_d;
  logic              valid_d, done_d, step;
  logic [LFSR_W-1:0] lfsr_q;
  logic [2:0]        step_bits;

  lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (step),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  // Data bits come from the value the LFSR takes on this very edge.
  assign step_bits = 3'(lfsr_next(lfsr_q));

  always_comb begin
    state_d = state_q;
    sel_d   = sel;
    count_d = count;
    in_d    = {in2, in1, in0};
    valid_d = 1'b0;
    done_d  = done;
    step    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          step    = 1'b1;
          sel_d   = SEL_IN0;
          count_d = 4'd1;
          done_d  = 1'b0;
        end
      end
      RUN: begin
        // hold wins over run completion, so a pause can occur at the last count
        if (hold) begin
          state_d = PAUSE;
        end else if (count == CNT_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          step    = 1'b1;
          sel_d   = (sel == SEL_IN2) ? SEL_IN0 : sel + 2'd1;
          count_d = count + 4'd1;
        end
      end
      PAUSE: begin
        if (!hold) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
    if (step) begin
      in_d    = step_bits;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      sel             <= SEL_IN0;
      count           <= 4'd0;
      {in2, in1, in0} <= 3'd0;
      valid           <= 1'b0;
      done            <= 1'b0;
    end else begin
      state_q         <= state_d;
      sel             <= sel_d;
      count           <= count_d;
      {in2, in1, in0} <= in_d;
      valid           <= valid_d;
      done            <= done_d;
    end
  end

endmodule

// File: tb/tb_mux_stim_gen.sv
// Bench for mux_stim_gen: behavioural model compared every cycle, directed
// scenarios with literal expectations, then a randomized phase.
module tb_mux_stim_gen;

  localparam int MAXC = 10;

  logic       clk = 1'b0;
  logic       rst_n, start, hold;
  logic       in0, in1, in2, valid, done;
  logic [1:0] sel;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;

  mux_stim_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .hold  (hold),
    .in0   (in0),
    .in1   (in1),
    .in2   (in2),
    .sel   (sel),
    .valid (valid),
    .count (count),
    .done  (done)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endfunction

  // Behavioural model: run phase, step count, LFSR value as plain integers.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_phase, m_lfsr, m_count, m_sel, m_in;
  bit m_valid, m_done, m_known = 0;

  task automatic model_step();
    m_lfsr  = ((m_lfsr << 1) & 8'hFF) | ($countones(m_lfsr & 8'hB8) & 1);
    m_in    = m_lfsr & 7;
    m_count = m_count + 1;
    m_sel   = (m_count - 1) % 3;
    m_valid = 1;
    m_done  = 0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_phase = M_IDLE; m_lfsr = 8'hA5; m_count = 0; m_sel = 0;
      m_in = 0; m_valid = 0; m_done = 0; m_known = 1;
    end else begin
      m_valid = 0;
      case (m_phase)
        M_IDLE, M_DONE:
          if (start) begin
            m_count = 0;
            model_step();
            m_phase = M_RUN;
          end
        M_RUN:
          if (hold) m_phase = M_PAUSE;
          else if (m_count == MAXC) begin
            m_phase = M_DONE;
            m_done  = 1;
          end else model_step();
        default:
          if (!hold) m_phase = M_RUN;
      endcase
    end
  endtask

  always @(posedge clk) begin
    model_edge();
    #2;
    if (m_known) begin
      chk("valid", valid, m_valid);
      chk("done", done, m_done);
      chk("count", count, m_count);
      chk("sel", sel, m_sel);
      chk("in_bits", {in2, in1, in0}, m_in);
    end
  end

  int nv;

  initial begin
    rst_n = 1'b0; start = 1'b0; hold = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;                       // must be ignored under reset
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_count", count, 0);
    chk("rst_sel", sel, 0);
    chk("rst_done", done, 0);
    chk("rst_lfsr", dut.u_lfsr.q, 8'hA5);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_valid", valid, 0);

    // Run 1: first steps pinned by hand, start pulse in RUN ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("s1_valid", valid, 1);
    chk("s1_sel", sel, 0);
    chk("s1_count", count, 1);
    chk("s1_in", {in2, in1, in0}, 3'b010);
    chk("s1_lfsr", dut.u_lfsr.q, 8'h4A);
    chk("s1_model_lfsr", m_lfsr, 8'h4A);
    @(negedge clk);
    chk("s2_sel", sel, 1);
    chk("s2_in", {in2, in1, in0}, 3'b101);
    chk("s2_lfsr", dut.u_lfsr.q, 8'h95);
    chk("s2_model_lfsr", m_lfsr, 8'h95);
    @(negedge clk);
    chk("s3_sel", sel, 2);
    @(negedge clk);
    chk("s4_sel", sel, 0);
    nv = 4;
    for (int i = 0; i < 40 && !done; i++) begin
      start = (i == 2);
      @(negedge clk);
      if (valid) nv++;
    end
    start = 1'b0;
    chk("run1_done", done, 1);
    chk("run1_valid_cycles", nv, MAXC);
    chk("run1_count", count, MAXC);
    chk("run1_valid_low", valid, 0);

    // Run 2: start from DONE, pause for 3 cycles at count 4.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("run2_count", count, 1);
    chk("run2_sel", sel, 0);
    nv = 1;
    for (int i = 0; i < 20 && count != 4; i++) begin
      @(negedge clk);
      if (valid) nv++;
    end
    chk("run2_reach4", count, 4);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (valid) nv++;
      chk("pause_valid", valid, 0);
      chk("pause_count", count, 4);
    end
    hold = 1'b0;
    @(negedge clk);
    if (valid) nv++;
    chk("resume_no_step", valid, 0);
    @(negedge clk);
    if (valid) nv++;
    chk("resume_step", valid, 1);
    chk("resume_count", count, 5);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (valid) nv++;
    end
    chk("run2_done", done, 1);
    chk("run2_valid_cycles", nv, MAXC);

    // Run 3: reset mid-run at count 6 with start asserted.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && count != 6; i++) @(negedge clk);
    chk("run3_reach6", count, 6);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk("midrst_count", count, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_lfsr", dut.u_lfsr.q, 8'hA5);
    start = 1'b0;
    @(negedge clk);
    chk("midrst_idle", valid, 0);
    rst_n = 1'b1;

    // Randomized phase; the model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      start = ($urandom_range(0, 3) == 0);
      hold  = ($urandom_range(0, 4) == 0);
      @(negedge clk);
    end
    rst_n = 1'b1; start = 1'b0; hold = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
